// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - instruction/memory handshake and datapath strobe bundle
// master: the control unit; slave: the instruction register, memory and datapath side.
interface multicycle_control_unit_if #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
);
  logic               instr_valid;
  logic [6:0]         instr_opcode;
  logic               mem_ready;
  logic               IRWrite;
  logic               PCWrite;
  logic               Branch;
  logic               MemRead;
  logic               MemWrite;
  logic               MemtoReg;
  logic [ALUOP_W-1:0] ALUOp;
  logic               ALUSrc;
  logic               RegWrite;
  logic               illegal_op;
  logic               busy;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  instr_valid, instr_opcode, mem_ready,
    output IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg,
           ALUOp, ALUSrc, RegWrite, illegal_op, busy, retired
  );

  modport slave (
    output instr_valid, instr_opcode, mem_ready,
    input  IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg,
           ALUOp, ALUSrc, RegWrite, illegal_op, busy, retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - RV32 multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer
// Define MCU_ITYPE_EN to accept OP-IMM (0010011); otherwise it decodes as illegal.
module multicycle_control_unit #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MCU_ITYPE_EN
  localparam logic [6:0] OP_IMM    = 7'b0010011;
`endif

  state_t             state, state_nxt;
  logic [6:0]         opcode_q;
  logic [CNT_W-1:0]   retired_q;
  logic               retire;
  logic               is_r, is_load, is_store, is_branch, is_imm, legal;
  logic               irw, pcw, br, mr, mw, m2r, src, rw, ill;
  logic [ALUOP_W-1:0] aluop;

  assign is_r      = (opcode_q == OP_R);
  assign is_load   = (opcode_q == OP_LOAD);
  assign is_store  = (opcode_q == OP_STORE);
  assign is_branch = (opcode_q == OP_BRANCH);
`ifdef MCU_ITYPE_EN
  assign is_imm    = (opcode_q == OP_IMM);
`else
  assign is_imm    = 1'b0;
`endif
  assign legal     = is_r | is_load | is_store | is_branch | is_imm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      opcode_q  <= '0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && bus.instr_valid)
        opcode_q <= bus.instr_opcode;
      if (retire)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    irw       = 1'b0;
    pcw       = 1'b0;
    br        = 1'b0;
    mr        = 1'b0;
    mw        = 1'b0;
    m2r       = 1'b0;
    src       = 1'b0;
    rw        = 1'b0;
    ill       = 1'b0;
    aluop     = '0;
    case (state)
      FETCH: begin
        irw = bus.instr_valid;
        if (bus.instr_valid)
          state_nxt = DECODE;
      end
      DECODE: begin
        if (legal) begin
          state_nxt = EXEC;
        end else begin
          ill       = 1'b1;
          pcw       = 1'b1;
          state_nxt = FETCH;
        end
      end
      EXEC: begin
        if (is_branch) begin
          aluop     = ALUOP_W'(2'b01);
          br        = 1'b1;
          pcw       = 1'b1;
          retire    = 1'b1;
          state_nxt = FETCH;
        end else if (is_load || is_store) begin
          src       = 1'b1;
          state_nxt = MEM;
        end else if (is_imm) begin
          src       = 1'b1;
          aluop     = ALUOP_W'(2'b11);
          state_nxt = WB;
        end else begin
          aluop     = ALUOP_W'(2'b10);
          state_nxt = WB;
        end
      end
      MEM: begin
        // Request stays up until the memory acknowledges.
        src = 1'b1;
        mr  = is_load;
        mw  = is_store;
        if (bus.mem_ready) begin
          if (is_store) begin
            pcw       = 1'b1;
            retire    = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        rw        = 1'b1;
        m2r       = is_load;
        pcw       = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Gated by reset so strobes (incl. the Mealy IRWrite) drop the instant reset asserts.
  assign bus.IRWrite    = reset & irw;
  assign bus.PCWrite    = reset & pcw;
  assign bus.Branch     = reset & br;
  assign bus.MemRead    = reset & mr;
  assign bus.MemWrite   = reset & mw;
  assign bus.MemtoReg   = reset & m2r;
  assign bus.ALUSrc     = reset & src;
  assign bus.RegWrite   = reset & rw;
  assign bus.illegal_op = reset & ill;
  assign bus.ALUOp      = reset ? aluop : '0;
  assign bus.busy       = reset & (state != FETCH);
  assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed bench with per-cycle instruction-level model
module tb_multicycle_control_unit;
  localparam int CNT_W = 2;
`ifdef MCU_ITYPE_EN
  localparam bit ITY = 1'b1;
`else
  localparam bit ITY = 1'b0;
`endif

  typedef struct {
    bit         v;
    logic [6:0] opc;
    bit         mrdy;
    bit         rst_after;
    bit         irw, pcw, br, mr, mw, m2r, src, rw, ill, busy;
    int         aluop;
    int         ret;
    int         lit;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  multicycle_control_unit_if #(.ALUOP_W(2), .CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(.ALUOP_W(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  cyc_t q[$];
  int   mret = 0;
  int   idx = -1;
  bit   active = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   mr_cycles = 0, mw_cycles = 0, ill_pulses = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  function automatic cyc_t blank();
    cyc_t c;
    c.v = 0; c.opc = 7'($urandom_range(0, 127)); c.mrdy = 1'($urandom_range(0, 1));
    c.rst_after = 0;
    c.irw = 0; c.pcw = 0; c.br = 0; c.mr = 0; c.mw = 0; c.m2r = 0;
    c.src = 0; c.rw = 0; c.ill = 0; c.busy = 0;
    c.aluop = 0; c.ret = mret; c.lit = -1;
    return c;
  endfunction

  function automatic void retire();
    mret = (mret + 1) % (1 << CNT_W);
  endfunction

  task automatic push_idle(input int n, input int lit);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = blank();
      if (k == 0) c.lit = lit;
      q.push_back(c);
    end
  endtask

  // Expands one instruction into the cycles it must occupy, from the phase rules.
  task automatic push_instr(input logic [6:0] op, input int waits, input bit abort, input int lit);
    cyc_t c;
    bit ld, st, bra, imm, legal;
    ld    = (op == 7'b0000011);
    st    = (op == 7'b0100011);
    bra   = (op == 7'b1100011);
    imm   = (op == 7'b0010011) && ITY;
    legal = ld || st || bra || imm || (op == 7'b0110011);

    c = blank(); c.v = 1; c.opc = op; c.irw = 1; c.lit = lit;
    q.push_back(c);
    c = blank(); c.busy = 1;
    if (!legal) begin
      c.ill = 1; c.pcw = 1;
      q.push_back(c);
      return;
    end
    q.push_back(c);
    c = blank(); c.busy = 1;
    if (bra) begin
      c.aluop = 1; c.br = 1; c.pcw = 1;
      q.push_back(c);
      retire();
      return;
    end
    if (ld || st) c.src = 1;
    else if (imm) begin c.src = 1; c.aluop = 3; end
    else c.aluop = 2;
    q.push_back(c);
    if (ld || st) begin
      for (int k = 0; k <= waits; k++) begin
        c = blank(); c.busy = 1; c.src = 1; c.mr = ld; c.mw = st;
        c.mrdy = (k == waits);
        if (abort) begin
          c.mrdy = 0; c.rst_after = 1;
          q.push_back(c);
          mret = 0;
          return;
        end
        if (st && k == waits) begin
          c.pcw = 1;
          q.push_back(c);
          retire();
          return;
        end
        q.push_back(c);
      end
    end
    c = blank(); c.busy = 1; c.rw = 1; c.pcw = 1; c.m2r = ld;
    q.push_back(c);
    retire();
  endtask

  task automatic cmp(input cyc_t c);
    chk("IRWrite",    bus.IRWrite,    c.irw);
    chk("PCWrite",    bus.PCWrite,    c.pcw);
    chk("Branch",     bus.Branch,     c.br);
    chk("MemRead",    bus.MemRead,    c.mr);
    chk("MemWrite",   bus.MemWrite,   c.mw);
    chk("MemtoReg",   bus.MemtoReg,   c.m2r);
    chk("ALUOp",      bus.ALUOp,      c.aluop);
    chk("ALUSrc",     bus.ALUSrc,     c.src);
    chk("RegWrite",   bus.RegWrite,   c.rw);
    chk("illegal_op", bus.illegal_op, c.ill);
    chk("busy",       bus.busy,       c.busy);
    chk("retired",    bus.retired,    c.ret);
    if (c.lit >= 0) chk("retired_literal", bus.retired, c.lit);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_IRWrite"},  bus.IRWrite,  0);
    chk({tag, "_PCWrite"},  bus.PCWrite,  0);
    chk({tag, "_MemRead"},  bus.MemRead,  0);
    chk({tag, "_MemWrite"}, bus.MemWrite, 0);
    chk({tag, "_RegWrite"}, bus.RegWrite, 0);
    chk({tag, "_ALUOp"},    bus.ALUOp,    0);
    chk({tag, "_ALUSrc"},   bus.ALUSrc,   0);
    chk({tag, "_busy"},     bus.busy,     0);
    chk({tag, "_retired"},  bus.retired,  0);
  endtask

  always @(negedge clk) begin
    #2;
    if (active) begin
      cmp(q[idx]);
      if (bus.MemRead)    mr_cycles++;
      if (bus.MemWrite)   mw_cycles++;
      if (bus.illegal_op) ill_pulses++;
    end
  end

  initial begin
    reset = 1'b0;
    bus.instr_valid  = 1'b1;
    bus.instr_opcode = 7'b0110011;
    bus.mem_ready    = 1'b1;

    push_instr(7'b0110011, 0, 0, 0);
    push_instr(7'b0000011, 2, 0, 1);
    push_instr(7'b0100011, 0, 0, 2);
    push_instr(7'b1100011, 0, 0, 3);
    push_idle(2, 0);
    push_instr(7'b0010011, 0, 0, 0);
    push_instr(7'b1111111, 0, 0, ITY ? 1 : 0);
    push_instr(7'b0000011, 0, 1, ITY ? 1 : 0);
    push_instr(7'b0110011, 0, 0, 0);
    push_instr(7'b0110011, 0, 0, 1);
    push_instr(7'b0110011, 0, 0, 2);
    push_instr(7'b0110011, 0, 0, 3);
    push_instr(7'b0110011, 0, 0, 0);
    push_instr(7'b0100011, 1, 0, 1);
    push_idle(1, 2);

    #12;
    chk_all_zero("reset_state");

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      reset            = 1'b1;
      idx              = i;
      bus.instr_valid  = q[i].v;
      bus.instr_opcode = q[i].opc;
      bus.mem_ready    = q[i].mrdy;
      active           = 1'b1;
      if (q[i].rst_after) begin
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        chk("reset_hold_busy",    bus.busy,    0);
        chk("reset_hold_retired", bus.retired, 0);
      end
    end
    @(negedge clk);
    active = 1'b0;

    chk("total_MemRead_cycles",  mr_cycles,  4);
    chk("total_MemWrite_cycles", mw_cycles,  3);
    chk("total_illegal_pulses",  ill_pulses, ITY ? 1 : 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
